// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD command queue.
//   state_e      - drain FSM states
//   lcd_entry_t  - one queued LCD byte with its register-select bit
//   OP_PUSH / OP_STATUS - custom-instruction opcodes (dataA[1])
//   FULL_CODE    - result returned for a push rejected by a full queue
//   INIT_*       - power-on controller init sequence (used when
//                  LCD_QUEUE_AUTOINIT_EN is defined)
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam logic        OP_PUSH   = 1'b0;
    localparam logic        OP_STATUS = 1'b1;
    localparam logic [31:0] FULL_CODE = 32'hFFFF_FFFF;

    localparam logic [7:0] INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] INIT_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] INIT_CLEAR    = 8'h01;  // clear display

    localparam int unsigned INIT_LEN   = 4;
    localparam int unsigned INIT_IDX_W = 2;
    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

    // Init sequence lookup, in issue order.
    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_FUNC_SET;
            2'd1:    b = INIT_DISP_ON;
            2'd2:    b = INIT_ENTRY;
            default: b = INIT_CLEAR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous FIFO of lcd_entry_t with occupancy count.
//   clk, reset_n  - clock, async active-low reset (clears pointers/count)
//   i_push/i_wdata - enqueue request; ignored when full
//   i_pop         - dequeue request; ignored when empty
//   o_rdata_c     - current head entry (combinational)
//   o_full_c/o_empty_c - status derived from the registered count
//   o_count       - registered occupancy, 0..DEPTH
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  lcd_entry_t    i_wdata,
    input  logic          i_pop,
    output lcd_entry_t    o_rdata_c,
    output logic          o_full_c,
    output logic          o_empty_c,
    output logic [CW-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    lcd_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata_c = r_mem[r_rd_ptr];

    assign w_push_ok = i_push & ~o_full_c;
    assign w_pop_ok  = i_pop & ~o_empty_c;

    // Storage array carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_queue.sv
// lcd_cmd_queue: custom-instruction front end that queues LCD bytes and
// drains them one at a time to a downstream byte writer.
//   clk, reset_n        - clock, async active-low reset
//   clk_en, start       - instruction request (start honoured only with clk_en)
//   dataA[1]            - opcode: 0 push, 1 status; dataA[0] = RS for push
//   dataB[7:0]          - LCD byte for push
//   result, done        - return value and one-cycle completion pulse
//   wr_start/wr_rs/wr_data - byte issue to downstream writer
//   wr_done             - downstream completion pulse (honoured in WAIT only)
// Build option: LCD_QUEUE_AUTOINIT_EN enables the power-on init sequence;
// when undefined the queue is ready straight out of reset.
module lcd_cmd_queue
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] result,
    output logic        done,
    output logic        wr_start,
    output logic        wr_rs,
    output logic [7:0]  wr_data,
    input  logic        wr_done
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_pop;
    logic          w_wr_start_nxt;
    logic          w_wr_rs_nxt;
    logic [7:0]    w_wr_data_nxt;
    logic          w_init_done;

    lcd_entry_t    w_head;
    lcd_entry_t    w_push_entry;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_after;

    logic          w_sample;
    logic          w_is_push;
    logic          w_fifo_push;
    logic          w_busy;
    logic [31:0]   w_status;
    logic          w_unused;

`ifdef LCD_QUEUE_AUTOINIT_EN
    logic [INIT_IDX_W-1:0] r_init_idx;
    logic [INIT_IDX_W-1:0] w_init_idx_nxt;
    logic                  r_init_done;
    logic                  w_init_done_nxt;

    assign w_init_done = r_init_done;
`else
    assign w_init_done = 1'b1;
`endif

    // Instruction decode; fullness is judged on the pre-edge count.
    assign w_sample     = clk_en & start;
    assign w_is_push    = (dataA[1] == OP_PUSH);
    assign w_fifo_push  = w_sample & w_is_push & ~w_full;
    assign w_push_entry = '{rs: dataA[0], data: dataB[7:0]};
    assign w_busy       = (r_state != ST_IDLE) | ~w_empty;
    assign w_status     = {22'b0, w_init_done, w_busy, 3'b0, 5'(w_count)};
    // Occupancy once this edge's push and any concurrent pop have landed.
    assign w_cnt_after  = w_count + CW'(1) - CW'(w_pop);
    assign w_unused     = ^{dataA[31:2], dataB[31:8]};

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_fifo_push),
        .i_wdata   (w_push_entry),
        .i_pop     (w_pop),
        .o_rdata_c (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    // Instruction result/done register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= w_sample;
            if (w_sample) begin
                if (!w_is_push) begin
                    result <= w_status;
                end else if (w_full) begin
                    result <= FULL_CODE;
                end else begin
                    result <= 32'(w_cnt_after);
                end
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef LCD_QUEUE_AUTOINIT_EN
            r_state <= ST_INIT;
`else
            r_state <= ST_IDLE;
`endif
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next-state and issue-register next values.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_wr_start_nxt = 1'b0;
        w_wr_rs_nxt    = wr_rs;
        w_wr_data_nxt  = wr_data;
`ifdef LCD_QUEUE_AUTOINIT_EN
        w_init_idx_nxt  = r_init_idx;
        w_init_done_nxt = r_init_done;
`endif
        case (r_state)
            ST_INIT: begin
`ifdef LCD_QUEUE_AUTOINIT_EN
                w_wr_rs_nxt    = 1'b0;
                w_wr_data_nxt  = init_rom(r_init_idx);
                w_wr_start_nxt = 1'b1;
                w_state_nxt    = ST_ISSUE;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (!w_empty && w_init_done) begin
                    w_pop          = 1'b1;
                    w_wr_rs_nxt    = w_head.rs;
                    w_wr_data_nxt  = w_head.data;
                    w_wr_start_nxt = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_done) begin
`ifdef LCD_QUEUE_AUTOINIT_EN
                    if (!r_init_done) begin
                        if (r_init_idx == INIT_LAST) begin
                            w_init_done_nxt = 1'b1;
                            w_state_nxt     = ST_IDLE;
                        end else begin
                            w_init_idx_nxt = r_init_idx + INIT_IDX_W'(1);
                            w_state_nxt    = ST_INIT;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue registers: wr_start pulses during ISSUE, rs/data held until next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_start <= 1'b0;
            wr_rs    <= 1'b0;
            wr_data  <= '0;
`ifdef LCD_QUEUE_AUTOINIT_EN
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
`endif
        end else begin
            wr_start <= w_wr_start_nxt;
            wr_rs    <= w_wr_rs_nxt;
            wr_data  <= w_wr_data_nxt;
`ifdef LCD_QUEUE_AUTOINIT_EN
            r_init_idx  <= w_init_idx_nxt;
            r_init_done <= w_init_done_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// tb_lcd_cmd_queue: directed and randomized checks of lcd_cmd_queue against
// a queue-based reference model of the command queue and byte drainer.
module tb_lcd_cmd_queue;

    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] result;
    logic        done;
    logic        wr_start;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        wr_done;

    lcd_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .start    (start),
        .dataA    (dataA),
        .dataB    (dataB),
        .result   (result),
        .done     (done),
        .wr_start (wr_start),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_done  (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending bytes, drainer phase, last instruction result.
    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_INIT  = 3;

    logic [8:0]  m_q [$];
    int          m_phase;
    logic [8:0]  m_cur;
    bit          m_init_done;
    int          m_idx;
    int          m_wcnt;
    logic [31:0] m_result;
    bit          m_done;

    logic [7:0]  rom [4];
    logic [8:0]  issued [$];

    int dly;
    bit stall;
    bit spur;
    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
`ifdef LCD_QUEUE_AUTOINIT_EN
        m_phase     = PH_INIT;
        m_init_done = 1'b0;
`else
        m_phase     = PH_IDLE;
        m_init_done = 1'b1;
`endif
        m_idx    = 0;
        m_wcnt   = 0;
        m_cur    = '0;
        m_result = '0;
        m_done   = 1'b0;
    endtask

    // Advance the model across one rising edge using pre-edge inputs.
    task automatic model_edge(input bit sampled, input logic [31:0] a, input logic [31:0] b,
                              input bit wd);
        int  cnt_pre;
        bit  busy_pre;
        bit  idone_pre;
        cnt_pre   = m_q.size();
        busy_pre  = (m_phase != PH_IDLE) || (cnt_pre != 0);
        idone_pre = m_init_done;
        case (m_phase)
            PH_IDLE: begin
                if (cnt_pre != 0 && m_init_done) begin
                    m_cur   = m_q.pop_front();
                    m_phase = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                m_phase = PH_WAIT;
                m_wcnt  = 0;
            end
            PH_WAIT: begin
                if (wd) begin
                    if (!m_init_done) begin
                        if (m_idx == 3) begin
                            m_init_done = 1'b1;
                            m_phase     = PH_IDLE;
                        end else begin
                            m_idx++;
                            m_phase = PH_INIT;
                        end
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end else begin
                    m_wcnt++;
                end
            end
            default: begin
                m_cur   = {1'b0, rom[m_idx]};
                m_phase = PH_ISSUE;
            end
        endcase
        m_done = sampled;
        if (sampled) begin
            if (a[1] == 1'b0) begin
                if (cnt_pre == DEPTH) begin
                    m_result = 32'hFFFF_FFFF;
                end else begin
                    m_q.push_back({a[0], b[7:0]});
                    m_result = 32'(m_q.size());
                end
            end else begin
                m_result = {22'b0, idone_pre, busy_pre, 3'b0, 5'(cnt_pre)};
            end
        end
    endtask

    // One clock of stimulus with model-driven downstream responder.
    task automatic step(input bit st, input bit ce, input logic [31:0] a, input logic [31:0] b);
        start   = st;
        clk_en  = ce;
        dataA   = a;
        dataB   = b;
        wr_done = ((m_phase == PH_WAIT) && !stall && (m_wcnt >= dly)) ||
                  ((m_phase != PH_WAIT) && spur && ($urandom_range(0, 3) == 0));
        @(posedge clk);
        model_edge(st && ce, a, b, wr_done);
        #1;
        chk("done", 32'(done), 32'(m_done));
        chk("result", result, m_result);
        chk("wr_start", 32'(wr_start), 32'(m_phase == PH_ISSUE));
        chk("wr_rs", 32'(wr_rs), 32'(m_cur[8]));
        chk("wr_data", 32'(wr_data), 32'(m_cur[7:0]));
        if (wr_start) issued.push_back({wr_rs, wr_data});
    endtask

    task automatic do_reset();
        wr_done = 1'b0;
        start   = 1'b0;
        clk_en  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_wr_start", 32'(wr_start), 32'h0);
        chk("rst_wr_rs", 32'(wr_rs), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef LCD_QUEUE_AUTOINIT_EN
        for (int i = 0; i < 200 && !m_init_done; i++) step(1'b0, 1'b0, '0, '0);
`endif
    endtask

    initial begin
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h06; rom[3] = 8'h01;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        clk_en  = 1'b0;
        start   = 1'b0;
        dataA   = '0;
        dataB   = '0;
        wr_done = 1'b0;
        dly     = 1;
        stall   = 1'b0;
        spur    = 1'b0;
        model_reset();

        // Reset, then (with auto-init) the controller init sequence.
        issued.delete();
        do_reset();
`ifdef LCD_QUEUE_AUTOINIT_EN
        chk("init_count", 32'(issued.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [8:0] got;
            got = (i < issued.size()) ? issued[i] : 9'h1FF;
            chk("init_byte", 32'(got), 32'({1'b0, rom[i]}));
        end
`endif
        step(1'b1, 1'b1, 32'h2, '0);
        chk("status_idle", result, 32'h0000_0200);

        // start without clk_en is ignored.
        step(1'b1, 1'b0, 32'h0, 32'h55);
        chk("ce0_no_done", 32'(done), 32'h0);
        step(1'b1, 1'b1, 32'h2, '0);
        chk("ce0_count", result, 32'h0000_0200);

        // Two RS=1 pushes behind a stalled in-flight byte.
        stall = 1'b1;
        step(1'b1, 1'b1, 32'h0, 32'h99);
        chk("dummy_push", result, 32'd1);
        repeat (3) step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'h1, 32'h41);
        chk("push41_done", 32'(done), 32'h1);
        chk("push41_res", result, 32'd1);
        step(1'b1, 1'b1, 32'h1, 32'h42);
        chk("push42_res", result, 32'd2);
        issued.delete();
        stall = 1'b0;
        dly   = 1;
        repeat (20) step(1'b0, 1'b0, '0, '0);
        chk("drain_count", 32'(issued.size()), 32'd2);
        if (issued.size() == 2) begin
            chk("drain_first", 32'(issued[0]), 32'h141);
            chk("drain_second", 32'(issued[1]), 32'h142);
        end

        // Fill to full, overflow, then push on the cycle the drainer pops.
        do_reset();
        stall = 1'b1;
        step(1'b1, 1'b1, 32'h0, 32'hAA);
        repeat (3) step(1'b0, 1'b0, '0, '0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 32'(i & 1), 32'(i));
            chk("fill_res", result, 32'(i));
        end
        step(1'b1, 1'b1, 32'h0, 32'h11);
        chk("overflow_res", result, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'h2, '0);
        chk("status_full", result, 32'h0000_0310);
        stall = 1'b0;
        dly   = 0;
        step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'h1, 32'h77);
        chk("full_pop_push", result, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'h2, '0);
        chk("status_15", result, 32'h0000_030F);

        // Reset while a byte is stuck in WAIT.
        stall = 1'b1;
        repeat (3) step(1'b0, 1'b0, '0, '0);
        chk("wait_data_pre", 32'(wr_data), 32'h01);
        do_reset();
        stall = 1'b0;
        step(1'b1, 1'b1, 32'h2, '0);
        chk("status_after_rst", result, 32'h0000_0200);

        // Randomized traffic with varying latency, stalls and stray wr_done.
        spur = 1'b1;
        for (int blk = 0; blk < 12; blk++) begin
            dly   = int'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 50; i++) begin
                logic [31:0] a;
                a    = $urandom;
                a[1] = ($urandom_range(0, 3) == 0);
                step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), a, $urandom);
            end
        end
        stall = 1'b0;
        dly   = 0;
        spur  = 1'b0;
        repeat (120) step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'h2, '0);
        chk("final_status", result, 32'h0000_0200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_queue.md
LCD_CMD_QUEUE -- requirements
Module: lcd_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, count width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_en  in  1  custom-instruction qualifier.
REQ-006 SHALL have port start  in  1  custom-instruction request.
REQ-007 SHALL have port dataA  in  32  bit1 opcode (0 push, 1 status); bit0 RS for push.
REQ-008 SHALL have port dataB  in  32  bits[7:0] LCD byte for push.
REQ-009 SHALL have port result  out  32  instruction return value.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port wr_start  out  1  one-cycle request to downstream LCD byte writer.
REQ-012 SHALL have port wr_rs  out  1  register-select for issued byte.
REQ-013 SHALL have port wr_data  out  8  issued byte.
REQ-014 SHALL have port wr_done  in  1  downstream completion pulse.

Function
REQ-015 SHALL store {rs, byte} 9-bit entries in a DEPTH-entry FIFO, count 0..DEPTH.
REQ-016 SHALL sample start only when clk_en=1; start with clk_en=0 is ignored.
REQ-017 Push with FIFO not full SHALL enqueue {dataA[0], dataB[7:0]}, result = count after push.
REQ-018 Push with FIFO full SHALL not enqueue, result = 32'hFFFF_FFFF.
REQ-019 Status SHALL return result = {22'b0, init_done, busy, 3'b0, count zero-extended to 5 bits}; busy = drain FSM not in IDLE or FIFO non-empty.
REQ-020 done SHALL pulse high exactly one cycle, the cycle after start sampled; result valid with done, held until next done.
REQ-021 Fullness SHALL be evaluated on pre-edge count; push-when-full plus same-cycle pop still rejects.
REQ-022 Same-cycle accepted push and pop SHALL leave count unchanged.
REQ-023 Drain FSM states: INIT, IDLE, ISSUE, WAIT.
REQ-024 IDLE: FIFO non-empty and init_done -> pop head into wr_rs/wr_data, go ISSUE; else stay.
REQ-025 ISSUE: wr_start=1 for exactly one cycle, go WAIT.
REQ-026 WAIT: stay until wr_done=1, then IDLE; wr_rs/wr_data held stable from ISSUE through WAIT exit.
REQ-027 wr_done outside WAIT SHALL be ignored.
REQ-028 Minimum spacing between consecutive wr_start pulses SHALL be 3 cycles (ISSUE, WAIT>=1, IDLE).
REQ-029 Drain FSM SHALL run irrespective of clk_en.
REQ-030 Pushes during INIT SHALL be accepted and held until init_done.

Reset
REQ-031 reset_n low SHALL asynchronously clear result, done, wr_start, wr_rs, wr_data, FIFO pointers and count to 0.
REQ-032 Reset SHALL put FSM in INIT (macro defined) or IDLE with init_done=1 (macro undefined).
REQ-033 Reset mid-WAIT SHALL abandon the in-flight byte; FIFO contents discarded.

Configuration
REQ-034 Macro LCD_QUEUE_AUTOINIT_EN defined: INIT issues, via ISSUE/WAIT handshake, RS=0 bytes 0x38, 0x0C, 0x06, 0x01 in order, then sets init_done=1, enters IDLE.
REQ-035 Macro undefined: no init ROM, init_done=1 from reset, INIT state unreachable.

Structure
REQ-036 Package lcd_pkg SHALL hold FSM state type, opcode constants (OP_PUSH, OP_STATUS), FULL reject code, init ROM byte constants and length.
REQ-037 FIFO SHALL be sub-module lcd_cmd_fifo (synchronous, push/pop/full/empty/count).

Verification
REQ-038 Macro on, reset release, wr_done 2 cycles after each wr_start -> wr_data 0x38,0x0C,0x06,0x01 with wr_rs=0, then status bit9=1.
REQ-039 Push RS=1 0x41 then 0x42 -> done each next cycle, result 1 then 2 (drain stalled); after drain wr_rs=1, wr_data 0x41 then 0x42.
REQ-040 wr_done held 0, push 17 times with DEPTH=16 -> results 1..16 then 0xFFFFFFFF; status count=16, busy=1.
REQ-041 Full FIFO, push on the cycle IDLE pops -> push rejected (0xFFFFFFFF), count 15 afterward.
REQ-042 start with clk_en=0 -> no done, count unchanged; reset_n low during WAIT -> wr_start, wr_data 0 immediately, count 0.
